// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants for the RGB LCD timing generator.
//   - default 480x272 panel timing and 800x480 alternates (pclk cycles / lines)
//   - counter width used by every scan counter
//   - colour constants for pattern sources
//   - backlight sequencer state encoding
package lcd_pkg;

  localparam int CNT_W = 11;

  // 480x272 panel
  localparam int H_SYNC_480  = 41;
  localparam int H_BACK_480  = 2;
  localparam int H_DISP_480  = 480;
  localparam int H_FRONT_480 = 2;
  localparam int V_SYNC_480  = 10;
  localparam int V_BACK_480  = 2;
  localparam int V_DISP_480  = 272;
  localparam int V_FRONT_480 = 2;

  // 800x480 panel
  localparam int H_SYNC_800  = 128;
  localparam int H_BACK_800  = 88;
  localparam int H_DISP_800  = 800;
  localparam int H_FRONT_800 = 40;
  localparam int V_SYNC_800  = 2;
  localparam int V_BACK_800  = 33;
  localparam int V_DISP_800  = 480;
  localparam int V_FRONT_800 = 10;

  localparam logic [23:0] WHITE = 24'hFF_FF_FF;
  localparam logic [23:0] BLACK = 24'h00_00_00;
  localparam logic [23:0] RED   = 24'hFF_00_00;
  localparam logic [23:0] GREEN = 24'h00_FF_00;
  localparam logic [23:0] BLUE  = 24'h00_00_FF;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_ON   = 1'b1
  } bl_state_t;

endpackage

// File: rtl/lcd_axis_cnt.sv
// lcd_axis_cnt: one scan axis (horizontal or vertical) of the LCD timing.
// Counts 0..SYNC+BACK+DISP+FRONT-1 while en is high and wraps to 0.
// Ports:
//   lcd_pclk, rst  pixel clock, async active-high reset
//   en             advance the count this cycle
//   cnt            current count (registered)
//   sync           count lies inside the sync pulse window
//   act            count lies inside the active (display) window
//   wrap           count is at its last value and en is high (wraps next edge)
module lcd_axis_cnt
  import lcd_pkg::*;
#(
  parameter int SYNC  = H_SYNC_480,
  parameter int BACK  = H_BACK_480,
  parameter int DISP  = H_DISP_480,
  parameter int FRONT = H_FRONT_480
) (
  input  logic             lcd_pclk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             sync,
  output logic             act,
  output logic             wrap
);

  localparam int TOTAL = SYNC + BACK + DISP + FRONT;

  // Compare one bit wider than the counter so a window ending exactly at
  // 2048 does not alias to 0.
  localparam logic [CNT_W:0] SYNC_END = 12'(SYNC);
  localparam logic [CNT_W:0] ACT_LO   = 12'(SYNC + BACK);
  localparam logic [CNT_W:0] ACT_HI   = 12'(SYNC + BACK + DISP);
  localparam logic [CNT_W:0] LAST     = 12'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_x;

  assign cnt_x = {1'b0, cnt_q};
  assign cnt   = cnt_q;
  assign sync  = (cnt_x < SYNC_END);
  assign act   = (cnt_x >= ACT_LO) && (cnt_x < ACT_HI);

  always_comb begin
    wrap  = en && (cnt_x == LAST);
    cnt_d = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_driver.sv
// lcd_driver: scan timing generator and pixel sink for a parallel RGB panel.
// Publishes the requested pixel position to a source, which returns the
// pixel one pclk later; that data is aligned with the registered panel pins.
// Ports:
//   lcd_pclk, rst            pixel clock, async active-high reset
//   pixel_data               RGB888 returned by the source
//   pixel_xpos, pixel_ypos   requested pixel (0 when not requesting)
//   h_disp, v_disp           active resolution constants
//   lcd_hs, lcd_vs           active-low syncs (registered)
//   lcd_de                   data enable (registered)
//   lcd_rgb                  pixel_data gated by lcd_de
//   lcd_bl                   backlight enable after STARTUP_FRAMES frames
//   frame_start              one-cycle pulse at the first pixel of each frame
//
// Backlight sequencer:
//   state  | meaning
//   S_WAIT | backlight off, counting completed frames
//   S_ON   | backlight on, held until reset
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int H_SYNC         = H_SYNC_480,
  parameter int H_BACK         = H_BACK_480,
  parameter int H_DISP         = H_DISP_480,
  parameter int H_FRONT        = H_FRONT_480,
  parameter int V_SYNC         = V_SYNC_480,
  parameter int V_BACK         = V_BACK_480,
  parameter int V_DISP         = V_DISP_480,
  parameter int V_FRONT        = V_FRONT_480,
  parameter int STARTUP_FRAMES = 2
) (
  input  logic             lcd_pclk,
  input  logic             rst,
  input  logic [23:0]      pixel_data,
  output logic [CNT_W-1:0] pixel_xpos,
  output logic [CNT_W-1:0] pixel_ypos,
  output logic [CNT_W-1:0] h_disp,
  output logic [CNT_W-1:0] v_disp,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic             lcd_de,
  output logic [23:0]      lcd_rgb,
  output logic             lcd_bl,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] H_OFS    = 11'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] V_OFS    = 11'(V_SYNC + V_BACK);
  localparam int               FRM_W    = $clog2(STARTUP_FRAMES + 1);
  localparam logic [FRM_W-1:0] FRM_DONE = FRM_W'(STARTUP_FRAMES);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_sync, h_act, h_wrap;
  logic             v_sync, v_act, v_wrap;
  logic             req;

  lcd_axis_cnt #(
    .SYNC (H_SYNC),
    .BACK (H_BACK),
    .DISP (H_DISP),
    .FRONT(H_FRONT)
  ) u_h_cnt (
    .lcd_pclk(lcd_pclk),
    .rst     (rst),
    .en      (1'b1),
    .cnt     (h_cnt),
    .sync    (h_sync),
    .act     (h_act),
    .wrap    (h_wrap)
  );

  lcd_axis_cnt #(
    .SYNC (V_SYNC),
    .BACK (V_BACK),
    .DISP (V_DISP),
    .FRONT(V_FRONT)
  ) u_v_cnt (
    .lcd_pclk(lcd_pclk),
    .rst     (rst),
    .en      (h_wrap),
    .cnt     (v_cnt),
    .sync    (v_sync),
    .act     (v_act),
    .wrap    (v_wrap)
  );

  assign h_disp = 11'(H_DISP);
  assign v_disp = 11'(V_DISP);

  always_comb begin
    req        = h_act && v_act;
    pixel_xpos = '0;
    pixel_ypos = '0;
    if (req) begin
      pixel_xpos = h_cnt - H_OFS;
      pixel_ypos = v_cnt - V_OFS;
    end
  end

  // One register stage on all panel pins so they line up with the data the
  // source returns one pclk after the request.
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic de_q, de_d;
  logic fs_q, fs_d;

  always_comb begin
    hs_d = !h_sync;
    vs_d = !v_sync;
    de_d = req;
    fs_d = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      de_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      fs_q <= fs_d;
    end
  end

  assign lcd_hs      = hs_q;
  assign lcd_vs      = vs_q;
  assign lcd_de      = de_q;
  assign frame_start = fs_q;
  assign lcd_rgb     = de_q ? pixel_data : 24'h0;

  bl_state_t        state_q, state_d;
  logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;

  // The frame count reaches STARTUP_FRAMES on the completing v wrap; the
  // state flips on the following edge so lcd_bl lands with frame_start.
  always_comb begin
    state_d   = state_q;
    frm_cnt_d = frm_cnt_q;
    case (state_q)
      S_WAIT: begin
        if (frm_cnt_q == FRM_DONE) begin
          state_d = S_ON;
        end else if (v_wrap) begin
          frm_cnt_d = frm_cnt_q + 1'b1;
        end
      end
      S_ON: begin
        state_d = S_ON;
      end
    endcase
  end

  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_WAIT;
      frm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      frm_cnt_q <= frm_cnt_d;
    end
  end

  assign lcd_bl = (state_q == S_ON);

endmodule

// File: tb/tb_lcd_driver.sv
module tb_lcd_driver;

  localparam int HS = 3;
  localparam int HB = 2;
  localparam int HD = 8;
  localparam int HF = 2;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int VD = 5;
  localparam int VF = 1;
  localparam int SF = 2;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FT = HT * VT;

  logic        lcd_pclk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pixel_data = 24'hFFFFFF;
  logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
  logic        lcd_hs, lcd_vs, lcd_de, lcd_bl, frame_start;
  logic [23:0] lcd_rgb;

  int checks = 0;
  int failures = 0;
  int k = 0;               // rising edges since reset release
  logic [23:0] exp_q[$];   // scoreboard of expected lcd_rgb while lcd_de

  lcd_driver #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .STARTUP_FRAMES(SF)
  ) dut (
    .lcd_pclk   (lcd_pclk),
    .rst        (rst),
    .pixel_data (pixel_data),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .h_disp     (h_disp),
    .v_disp     (v_disp),
    .lcd_hs     (lcd_hs),
    .lcd_vs     (lcd_vs),
    .lcd_de     (lcd_de),
    .lcd_rgb    (lcd_rgb),
    .lcd_bl     (lcd_bl),
    .frame_start(frame_start)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  always @(posedge lcd_pclk) k = rst ? 0 : k + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_act(input int h, input int v);
    return (h >= HS + HB) && (h < HS + HB + HD) && (v >= VS + VB) && (v < VS + VB + VD);
  endfunction

  // Source: registers {y[7:0], x, 5'b0} xor a random mask one pclk after the
  // request; idle cycles get random data (often all ones) that must not leak.
  initial begin : driver
    int q, h, v;
    bit req;
    logic [23:0] rnd, nxt;
    forever begin
      @(negedge lcd_pclk);
      nxt = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom);
      if (!rst) begin
        q = k % FT;
        h = q % HT;
        v = q / HT;
        req = in_act(h, v);
        chk("pixel_xpos", int'(pixel_xpos), req ? h - (HS + HB) : 0);
        chk("pixel_ypos", int'(pixel_ypos), req ? v - (VS + VB) : 0);
        if (req) begin
          rnd = 24'($urandom);
          exp_q.push_back({8'(v - (VS + VB)), 11'(h - (HS + HB)), 5'b0} ^ rnd);
          nxt = {pixel_ypos[7:0], pixel_xpos, 5'b0} ^ rnd;
        end
      end
      @(posedge lcd_pclk);
      #1;
      pixel_data = nxt;
    end
  end

  initial begin : monitor
    int q, h, v, t_hs, t_de, t_fs, lines;
    bit have_hs, have_de, have_fs;
    logic prev_hs, prev_de;
    have_hs = 0; have_de = 0; have_fs = 0; lines = 0;
    t_hs = 0; t_de = 0; t_fs = 0;
    prev_hs = 1'b1; prev_de = 1'b0;
    forever begin
      @(negedge lcd_pclk);
      if (rst) begin
        chk("rst_hs", int'(lcd_hs), 1);
        chk("rst_vs", int'(lcd_vs), 1);
        chk("rst_de", int'(lcd_de), 0);
        chk("rst_rgb", int'(lcd_rgb), 0);
        chk("rst_bl", int'(lcd_bl), 0);
        chk("rst_fs", int'(frame_start), 0);
        chk("rst_xpos", int'(pixel_xpos), 0);
        chk("rst_ypos", int'(pixel_ypos), 0);
        have_hs = 0; have_de = 0; have_fs = 0; lines = 0;
        prev_hs = 1'b1; prev_de = 1'b0;
      end else begin
        q = (k - 1) % FT;
        h = q % HT;
        v = q / HT;
        chk("lcd_hs", int'(lcd_hs), int'(h >= HS));
        chk("lcd_vs", int'(lcd_vs), int'(v >= VS));
        chk("lcd_de", int'(lcd_de), int'(in_act(h, v)));
        chk("frame_start", int'(frame_start), int'(q == 0));
        chk("lcd_bl", int'(lcd_bl), int'(k >= SF * FT + 1));
        if (lcd_de) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL lcd_rgb_queue actual=empty required=entry t=%0t", $time);
          end else begin
            chk("lcd_rgb", int'(lcd_rgb), int'(exp_q.pop_front()));
          end
        end else begin
          chk("lcd_rgb_idle", int'(lcd_rgb), 0);
        end
        if (prev_hs && !lcd_hs) begin
          if (have_hs) chk("hs_period", k - t_hs, HT);
          t_hs = k;
          have_hs = 1;
        end
        if (!prev_hs && lcd_hs && have_hs) chk("hs_width", k - t_hs, HS);
        if (!prev_de && lcd_de) begin
          if (have_hs) chk("de_offset", k - t_hs, HS + HB);
          t_de = k;
          have_de = 1;
          lines++;
        end
        if (prev_de && !lcd_de && have_de) chk("de_width", k - t_de, HD);
        if (frame_start) begin
          if (have_fs) begin
            chk("fs_period", k - t_fs, FT);
            chk("active_lines", lines, VD);
          end
          t_fs = k;
          have_fs = 1;
          lines = 0;
        end
        prev_hs = lcd_hs;
        prev_de = lcd_de;
      end
    end
  end

  initial begin : main
    bit found;
    rst = 1'b1;
    repeat (3) @(posedge lcd_pclk);
    @(negedge lcd_pclk);
    #2;
    chk("h_disp", int'(h_disp), HD);
    chk("v_disp", int'(v_disp), VD);
    rst = 1'b0;
    repeat (3 * FT + 20) @(posedge lcd_pclk);

    // Reset mid-frame at an active pixel (h=9, v=4) with backlight already on.
    found = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      @(posedge lcd_pclk);
      #2;
      if (k % FT == 4 * HT + 9) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL seek_mid_frame actual=not_found required=found");
    end else begin
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("async_hs", int'(lcd_hs), 1);
      chk("async_vs", int'(lcd_vs), 1);
      chk("async_de", int'(lcd_de), 0);
      chk("async_rgb", int'(lcd_rgb), 0);
      chk("async_bl", int'(lcd_bl), 0);
      chk("async_xpos", int'(pixel_xpos), 0);
      repeat (3) @(posedge lcd_pclk);
      @(negedge lcd_pclk);
      #2;
      rst = 1'b0;
    end
    repeat (3 * FT + 20) @(posedge lcd_pclk);
    @(negedge lcd_pclk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_driver.md
# lcd_driver

Timing generator and pixel sink for the parallel RGB LCD panel; the consumer end of the pixel-position/pixel-data interface. It produces the horizontal and vertical scan, publishes `pixel_xpos`/`pixel_ypos` to the pattern source, and takes back `pixel_data`, which the source registers one `lcd_pclk` later. It drives the panel's `lcd_hs`, `lcd_vs`, `lcd_de`, `lcd_rgb` and backlight enable. It sits between any pixel source and the panel pins.

## Interface
- `H_SYNC`, 41: hsync pulse width, pclk cycles
- `H_BACK`, 2: horizontal back porch
- `H_DISP`, 480: active pixels per line
- `H_FRONT`, 2: horizontal front porch
- `V_SYNC`, 10: vsync pulse width, lines
- `V_BACK`, 2: vertical back porch
- `V_DISP`, 272: active lines per frame
- `V_FRONT`, 2: vertical front porch
- `STARTUP_FRAMES`, 2: complete frames before backlight enable; must be ≥1
- One clock; reset is asynchronous and active-high.
- `lcd_pclk` in 1: pixel clock, the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `pixel_data` in 24: RGB888 from the source, valid one cycle after the matching position.
- `pixel_xpos` out 11: column of the pixel being requested; 0 when not requesting.
- `pixel_ypos` out 11: row of the pixel being requested; 0 when not requesting.
- `h_disp` out 11: constant `H_DISP`.
- `v_disp` out 11: constant `V_DISP`.
- `lcd_hs` out 1: hsync, active-low, registered.
- `lcd_vs` out 1: vsync, active-low, registered.
- `lcd_de` out 1: data enable, active-high, registered.
- `lcd_rgb` out 24: `pixel_data` when `lcd_de`, else 0.
- `lcd_bl` out 1: backlight enable, registered.
- `frame_start` out 1: one-cycle pulse, registered.

## Operation
- `H_TOTAL` is the sum of the four H parameters, 525 by default. `V_TOTAL` is the sum of the four V parameters, 286 by default. Both must be ≤2048. All counters are 11 bit.
- `h_cnt` counts 0..`H_TOTAL`-1 and wraps to 0.
- `v_cnt` increments when `h_cnt` wraps. It wraps to 0 when it is at `V_TOTAL`-1 and `h_cnt` wraps.
- Raw decodes from the counter registers (stage 0):
  - `hs_raw` = `h_cnt` < `H_SYNC`; `vs_raw` = `v_cnt` < `V_SYNC`.
  - `h_act` = `h_cnt` in [`H_SYNC`+`H_BACK`, `H_SYNC`+`H_BACK`+`H_DISP`-1]; `v_act` is the same rule on `v_cnt`.
  - `req` = `h_act` and `v_act`.
- Request outputs:
  - `pixel_xpos` = `req` ? `h_cnt`-(`H_SYNC`+`H_BACK`) : 0.
  - `pixel_ypos` = `req` ? `v_cnt`-(`V_SYNC`+`V_BACK`) : 0.
  - Both are combinational from the counter registers.
- Stage 1, registered on every clock:
  - `lcd_hs` <= !`hs_raw`; `lcd_vs` <= !`vs_raw`; `lcd_de` <= `req`.
  - `frame_start` <= (`h_cnt`==0 and `v_cnt`==0).
- Returned data is aligned with `lcd_de` with no further delay; `lcd_rgb` = `lcd_de` ? `pixel_data` : 24'h0.
- Backlight FSM, states `S_WAIT` and `S_ON`:
  - `S_WAIT`: `lcd_bl`=0. `frm_cnt` increments on each v wrap. When `frm_cnt` reaches `STARTUP_FRAMES`, the FSM moves to `S_ON`.
  - `S_ON`: `lcd_bl`=1. The FSM stays here until reset; `frm_cnt` holds.

## Timing
- Reset values:
  - `h_cnt`=0, `v_cnt`=0, `frm_cnt`=0, FSM=`S_WAIT`.
  - `lcd_hs`=1, `lcd_vs`=1, `lcd_de`=0, `frame_start`=0, `lcd_bl`=0.
  - Hence `lcd_rgb`=0 and `pixel_xpos`/`pixel_ypos`=0.
- First rising `lcd_pclk` after `rst` deasserts: counters begin advancing, and `lcd_hs`/`lcd_vs` go low (counters at 0 lie inside both sync windows).
- `frame_start` pulses on the first clock after reset release.
- Latency:
  - Position to `lcd_de`/`lcd_rgb`: 1 cycle.
  - `lcd_hs`/`lcd_vs` share the same 1-cycle delay, so all panel pins are mutually aligned.
- Per line:
  - `lcd_hs` is low for `H_SYNC` cycles; hsync falling edges are exactly `H_TOTAL` cycles apart.
  - `lcd_de` is high for `H_DISP` consecutive cycles. It rises `H_SYNC`+`H_BACK` cycles after the `lcd_hs` falling edge.
- Per frame:
  - `lcd_vs` is low for `V_SYNC`×`H_TOTAL` cycles.
  - `lcd_de` is active on `V_DISP` lines.
  - `frame_start` period is `H_TOTAL`×`V_TOTAL` cycles.
- Simultaneous h and v wrap: `v_cnt` goes to 0 in the same cycle that `h_cnt` goes to 0.
- `lcd_bl` rises 1 cycle after the v wrap that completes frame `STARTUP_FRAMES`.
- Reset asserted mid-line or mid-frame: every output returns to its reset value immediately (asynchronous), and the backlight sequence restarts.

## Structure
- Shared package `lcd_pkg`:
  - Default timing constants for 480×272 (plus 800×480 alternates).
  - Colour constants WHITE/BLACK/RED/GREEN/BLUE.
  - FSM state encoding.
- One sub-module, `lcd_axis_cnt`:
  - Parameterised `SYNC`/`BACK`/`DISP`/`FRONT`.
  - Inputs: enable. Outputs: count, `sync`, `act`, `wrap`.
  - Instantiated once for H (enable=1) and once for V (enable=H wrap).

## Test plan
- Reset, then release → `lcd_hs`=`lcd_vs`=1, `lcd_de`=0, `lcd_rgb`=0, `lcd_bl`=0 during reset; `frame_start`=1 on the first clock after release.
- Free run with defaults → hsync falling edges 525 cycles apart, low 41 cycles; `lcd_de` rises 43 cycles after each hsync fall and stays high 480 cycles; 272 active lines; `frame_start` period 150150.
- Model a source that returns {`pixel_ypos`[7:0], `pixel_xpos`[10:0], 5'b0} registered → `lcd_rgb` shows x 0..479 and y 0..271 in raster order with no skipped or duplicated pixel.
- `pixel_data` tied to 24'hFFFFFF → `lcd_rgb`=24'h0 in every cycle with `lcd_de`=0.
- `STARTUP_FRAMES`=2 → `lcd_bl` stays 0 through 2 frames and rises 1 cycle after the second v wrap.
- Assert `rst` for 3 cycles at `h_cnt`=300, `v_cnt`=100 → outputs go to reset values asynchronously; after release, timing restarts from `h_cnt`=0/`v_cnt`=0 and `lcd_bl` needs 2 more frames to rise.
